// File: rtl/seq_detect_mealy.sv
// rtl/seq_detect_mealy.sv - serial PAT_W-bit pattern detector with Mealy match output
// Optional saturating match counter enabled by defining SEQ_DET_MATCH_CNT_EN.
module seq_detect_mealy #(
   parameter int               PAT_W       = 3,
   parameter logic [PAT_W-1:0] DEF_PATTERN = 3'b111,
   parameter logic             DEF_OVERLAP = 1'b0,
   parameter int               CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic             in_bit,
   input  logic             cfg_we,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic             cfg_overlap,
   output logic             match,
   output logic             match_q,
   output logic             armed
`ifdef SEQ_DET_MATCH_CNT_EN
   ,
   output logic [CNT_W-1:0] match_cnt
`endif
);

   localparam int               FILL_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
   localparam logic [FILL_W-1:0] FULL  = FILL_W'(PAT_W - 1);

   typedef enum logic {FILL, ARMED} state_t;

   generate
      if (PAT_W < 2 || CNT_W < 1) begin : g_bad_param
         $error("seq_detect_mealy: PAT_W must be >= 2 and CNT_W >= 1");
      end
   endgenerate

   state_t             state_q, state_d;
   logic [PAT_W-2:0]   hist_q, hist_d;
   logic [FILL_W-1:0]  fill_q, fill_d;
   logic [PAT_W-1:0]   pattern_q, pattern_d;
   logic               overlap_q, overlap_d;
   logic [PAT_W-1:0]   window;
   logic               accept;

   // match is formed only from registered state plus the live input bit
   always_comb begin
      accept    = in_valid & ~cfg_we & ~rst;
      window    = {hist_q, in_bit};
      match     = accept & (state_q == ARMED) & (window == pattern_q);
      armed     = (state_q == ARMED) & ~rst;
      hist_d    = hist_q;
      fill_d    = fill_q;
      pattern_d = pattern_q;
      overlap_d = overlap_q;
      if (cfg_we) begin
         pattern_d = cfg_pattern;
         overlap_d = cfg_overlap;
         hist_d    = '0;
         fill_d    = '0;
      end else if (in_valid) begin
         if (match && !overlap_q) begin
            hist_d = '0;
            fill_d = '0;
         end else begin
            hist_d = window[PAT_W-2:0];
            fill_d = (fill_q == FULL) ? FULL : fill_q + 1'b1;
         end
      end
      state_d = (fill_d == FULL) ? ARMED : FILL;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= FILL;
         hist_q    <= '0;
         fill_q    <= '0;
         pattern_q <= DEF_PATTERN;
         overlap_q <= DEF_OVERLAP;
         match_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         hist_q    <= hist_d;
         fill_q    <= fill_d;
         pattern_q <= pattern_d;
         overlap_q <= overlap_d;
         match_q   <= match;
      end
   end

`ifdef SEQ_DET_MATCH_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || cfg_we) begin
         cnt_q <= '0;
      end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign match_cnt = cnt_q;
`endif

endmodule
